// File: rtl/prm_edge_chk_engine.sv
// prm_edge_chk_engine
// Streaming roadmap-edge collision checker. Every channel owns a 2**CODE_W x 1
// occupancy table held in synchronous RAM and loaded at run time. A stream of
// configuration codes for one edge is looked up in all tables. The per-channel
// hits are OR-reduced over the edge, and one result (mask, hit, sample count)
// is returned per edge.
// Optional build macro: PRM_EARLY_EXIT_EN. When it is defined, lookups stop as
// soon as every enabled channel has hit, and m_count reports the 1-based index
// of the sample that completed the hit.
module prm_edge_chk_engine #(
  parameter int CODE_W = 15,
  parameter int N_CHK  = 4,
  parameter int CNT_W  = 10,
  localparam int CH_W  = (N_CHK > 1) ? $clog2(N_CHK) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CODE_W-1:0] cfg_addr,
  input  logic              cfg_wdata,
  output logic              cfg_err,
  input  logic              cfg_err_clr,
  input  logic [N_CHK-1:0]  chan_en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CODE_W-1:0] s_code,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N_CHK-1:0]  m_mask,
  output logic              m_hit,
  output logic [CNT_W-1:0]  m_count
);

  localparam int              DEPTH   = 1 << CODE_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CH_W:0]   N_CHK_L = (CH_W + 1)'(N_CHK);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_s_ready;
  logic               r_drain_cnt;

  logic               w_accept;
  logic               w_first;
  logic               w_cfg_ok;
  logic               w_cfg_bad;
  logic               w_rd_en;
  logic               w_done;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [CNT_W-1:0]   w_cnt_out;

  logic [N_CHK-1:0]   r_mem [0:DEPTH-1];
  logic [N_CHK-1:0]   r_rd;

  logic               r_p1_vld;
  logic               r_p2_vld;
  logic [N_CHK-1:0]   r_p2_hit;
  logic [N_CHK-1:0]   r_acc;
  logic [N_CHK-1:0]   r_en_q;
  logic [CNT_W-1:0]   r_cnt;

  logic               r_m_valid;
  logic [N_CHK-1:0]   r_m_mask;
  logic               r_m_hit;
  logic [CNT_W-1:0]   r_m_count;
  logic               r_cfg_err;

  assign w_accept  = s_valid & r_s_ready;
  assign w_first   = w_accept & (r_state == ST_IDLE);
  assign w_cfg_ok  = cfg_we & (r_state == ST_IDLE) & ({1'b0, cfg_ch} < N_CHK_L);
  assign w_cfg_bad = cfg_we & ~w_cfg_ok;
  assign w_rd_en   = w_accept & ~w_done;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? CNT_MAX : (r_cnt + CNT_W'(1));

  // FSM state register plus registered copy of s_ready derived from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_s_ready   <= 1'b1;
      r_drain_cnt <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_s_ready   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ACCUM);
      r_drain_cnt <= (r_state == ST_DRAIN) && !r_drain_cnt;
    end
  end

  // FSM next-state decode: accept samples, drain the pipeline, hold the result
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = s_last ? ST_DRAIN : ST_ACCUM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (w_accept && s_last) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt) begin
          w_state_nxt = ST_RESULT;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_RESULT: begin
        if (r_m_valid && m_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESULT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Table RAM: lookup reads the old contents when a write hits the same word
  always_ff @(posedge clk) begin
    if (w_rd_en) begin
      r_rd <= r_mem[s_code];
    end
    if (w_cfg_ok) begin
      r_mem[cfg_addr][cfg_ch] <= cfg_wdata;
    end
  end

  // Lookup pipeline, enable latch, accumulator and saturating sample counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_vld <= 1'b0;
      r_p2_vld <= 1'b0;
      r_p2_hit <= '0;
      r_acc    <= '0;
      r_en_q   <= '0;
      r_cnt    <= '0;
    end else begin
      r_p1_vld <= w_rd_en;
      r_p2_vld <= r_p1_vld;
      r_p2_hit <= r_rd & r_en_q;
      if (w_first) begin
        r_en_q <= chan_en;
        r_cnt  <= CNT_W'(1);
        r_acc  <= '0;
      end else begin
        if (w_accept) begin
          r_cnt <= w_cnt_inc;
        end
        if (r_p2_vld) begin
          r_acc <= r_acc | r_p2_hit;
        end
      end
    end
  end

`ifdef PRM_EARLY_EXIT_EN
  logic             r_done;
  logic [CNT_W-1:0] r_p1_cnt;
  logic [CNT_W-1:0] r_p2_cnt;
  logic [CNT_W-1:0] r_cnt_frz;
  logic [CNT_W-1:0] w_cnt_now;

  assign w_cnt_now = w_first ? CNT_W'(1) : w_cnt_inc;
  // A completed hit left over from the previous edge must not gate a new edge
  assign w_done    = r_done & (r_state != ST_IDLE);
  assign w_cnt_out = r_done ? r_cnt_frz : r_cnt;

  // Carry each sample's index down the pipeline and freeze it at full hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done    <= 1'b0;
      r_p1_cnt  <= '0;
      r_p2_cnt  <= '0;
      r_cnt_frz <= '0;
    end else begin
      r_p1_cnt <= w_cnt_now;
      r_p2_cnt <= r_p1_cnt;
      if (w_first) begin
        r_done <= 1'b0;
      end else if (r_p2_vld && !r_done && (|r_en_q) &&
                   ((r_acc | r_p2_hit) == r_en_q)) begin
        r_done    <= 1'b1;
        r_cnt_frz <= r_p2_cnt;
      end
    end
  end
`else
  assign w_done    = 1'b0;
  assign w_cnt_out = r_cnt;
`endif

  // Result registers: load once on entry to RESULT, hold until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_mask  <= '0;
      r_m_hit   <= 1'b0;
      r_m_count <= '0;
    end else if ((r_state == ST_RESULT) && !r_m_valid) begin
      r_m_valid <= 1'b1;
      r_m_mask  <= r_acc;
      r_m_hit   <= |r_acc;
      r_m_count <= w_cnt_out;
    end else if (r_m_valid && m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  // Sticky configuration error; an illegal write wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_err <= 1'b0;
    end else if (w_cfg_bad) begin
      r_cfg_err <= 1'b1;
    end else if (cfg_err_clr) begin
      r_cfg_err <= 1'b0;
    end
  end

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_mask  = r_m_mask;
  assign m_hit   = r_m_hit;
  assign m_count = r_m_count;
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_prm_edge_chk_engine.sv
// Self-checking bench for prm_edge_chk_engine. It uses randomized edges and
// checks each result against a table-lookup model computed per edge.
module tb_prm_edge_chk_engine;

  localparam int CODE_W = 15;
  localparam int N_CHK  = 4;
  localparam int CNT_W  = 10;
  localparam logic [14:0] A_ALL = 15'h0ABC;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [CODE_W-1:0] cfg_addr;
  logic              cfg_wdata;
  logic              cfg_err;
  logic              cfg_err_clr;
  logic [N_CHK-1:0]  chan_en;
  logic              s_valid;
  logic              s_ready;
  logic [CODE_W-1:0] s_code;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [N_CHK-1:0]  m_mask;
  logic              m_hit;
  logic [CNT_W-1:0]  m_count;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [3:0]  tbl [0:32767];
  logic [14:0] pool [0:15];
  logic [14:0] codes [$];

  always #5 clk = ~clk;

  prm_edge_chk_engine #(.CODE_W(CODE_W), .N_CHK(N_CHK), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err), .cfg_err_clr(cfg_err_clr), .chan_en(chan_en),
    .s_valid(s_valid), .s_ready(s_ready), .s_code(s_code), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_mask(m_mask), .m_hit(m_hit),
    .m_count(m_count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_s_ready"}, s_ready, 1);
    check_val({tag, "_m_valid"}, m_valid, 0);
    check_val({tag, "_m_mask"}, m_mask, 0);
    check_val({tag, "_m_hit"}, m_hit, 0);
    check_val({tag, "_m_count"}, m_count, 0);
    check_val({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  // Legal table write; call only while the engine is idle.
  task automatic cfg_write(input logic [1:0] ch, input logic [14:0] addr, input logic b);
    cfg_we = 1'b1; cfg_ch = ch; cfg_addr = addr; cfg_wdata = b;
    @(negedge clk);
    cfg_we = 1'b0;
    tbl[addr][ch] = b;
  endtask

  // Send the edge held in 'codes' and check its result. The first beat may
  // carry a concurrent table write. abort_at >= 0 pulses reset at that sample.
  task automatic run_edge(input int n, input logic [3:0] en, input int stall,
                          input bit stall_cfg, input bit cw, input logic [1:0] cw_ch,
                          input logic [14:0] cw_addr, input logic cw_bit, input int abort_at);
    logic [3:0] exp_mask;
    logic [3:0] v;
    int exp_cnt;
    int full_at;
    int lat;
    int seen;
    exp_mask = 4'h0;
    full_at  = 0;
    for (int i = 0; i < n; i++) begin
      v = tbl[codes[i]] & en;
      if (i == 0 && cw) tbl[cw_addr][cw_ch] = cw_bit;
      exp_mask = exp_mask | v;
      if (full_at == 0 && en != 4'h0 && exp_mask == en) full_at = i + 1;
    end
    exp_cnt = (n > 1023) ? 1023 : n;
`ifdef PRM_EARLY_EXIT_EN
    if (full_at != 0) exp_cnt = full_at;
`endif
    chan_en = en;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        s_valid = 1'b0; s_last = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (m_valid) seen++;
        end
        check_val("abort_no_m_valid", seen, 0);
        check_idle_outputs("abort");
        return;
      end
      if ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1; s_code = codes[i]; s_last = (i == n - 1);
      if (i == 0 && cw) begin
        cfg_we = 1'b1; cfg_ch = cw_ch; cfg_addr = cw_addr; cfg_wdata = cw_bit;
      end
      check_val("s_ready_accept", s_ready, 1);
      @(negedge clk);
      cfg_we = 1'b0;
      if (i == 0) chan_en = 4'($urandom);
    end
    s_valid = 1'b0; s_last = 1'b0;
    check_val("s_ready_drain", s_ready, 0);
    lat = 0;
    while (!m_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_val("latency", lat, 3);
    check_val("m_mask", m_mask, exp_mask);
    check_val("m_hit", m_hit, |exp_mask);
    check_val("m_count", m_count, exp_cnt);
    for (int k = 0; k < stall; k++) begin
      check_val("hold_m_valid", m_valid, 1);
      check_val("hold_s_ready", s_ready, 0);
      check_val("hold_m_mask", m_mask, exp_mask);
      check_val("hold_m_count", m_count, exp_cnt);
      if (stall_cfg) begin
        if (k == 0) begin
          cfg_we = 1'b1; cfg_ch = 2'd1; cfg_addr = 15'h1234; cfg_wdata = 1'b1;
        end else if (k == 1) begin
          check_val("cfg_err_set", cfg_err, 1);
          cfg_err_clr = 1'b1;
        end else if (k == 2) begin
          check_val("cfg_err_clr_vs_bad", cfg_err, 1);
          cfg_we = 1'b0;
        end else if (k == 3) begin
          check_val("cfg_err_cleared", cfg_err, 0);
          cfg_err_clr = 1'b0;
        end
      end
      @(negedge clk);
    end
    cfg_we = 1'b0; cfg_err_clr = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check_val("m_valid_after_hs", m_valid, 0);
    check_val("s_ready_after_hs", s_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_addr = 15'h0; cfg_wdata = 1'b0;
    cfg_err_clr = 1'b0; chan_en = 4'h0; s_valid = 1'b0; s_code = 15'h0;
    s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");

    pool[0] = 15'h0001; pool[1] = 15'h1234; pool[2] = 15'h7FFF; pool[3] = A_ALL;
    for (int p = 4; p < 16; p++) pool[p] = 15'($urandom);
    for (int p = 4; p < 16; p++)
      for (int c = 0; c < 4; c++) cfg_write(2'(c), pool[p], 1'($urandom_range(0, 1)));
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 4; c++) cfg_write(2'(c), pool[p], 1'b0);
    cfg_write(2'd0, 15'h1234, 1'b1);
    for (int c = 0; c < 4; c++) cfg_write(2'(c), A_ALL, 1'b1);

    codes = '{15'h0001, 15'h1234, 15'h7FFF};
    run_edge(3, 4'hF, 0, 0, 0, 2'd0, 15'h0, 1'b0, -1);
    run_edge(3, 4'hE, 0, 0, 0, 2'd0, 15'h0, 1'b0, -1);
    codes = '{15'h0001};
    run_edge(1, 4'hF, 0, 0, 0, 2'd0, 15'h0, 1'b0, -1);
    codes = '{15'h1234};
    run_edge(1, 4'hF, 5, 1, 0, 2'd0, 15'h0, 1'b0, -1);
    codes = '{15'h1234, 15'h1234};
    run_edge(2, 4'hF, 1, 0, 0, 2'd0, 15'h0, 1'b0, -1);
    codes = '{15'h0001};
    run_edge(1, 4'hF, 0, 0, 1, 2'd2, 15'h0001, 1'b1, -1);
    run_edge(1, 4'hF, 0, 0, 0, 2'd0, 15'h0, 1'b0, -1);
    cfg_write(2'd2, 15'h0001, 1'b0);
    codes = '{15'h0001, A_ALL, 15'h1234, 15'h0001, 15'h7FFF, 15'h1234};
    run_edge(6, 4'hF, 2, 0, 0, 2'd0, 15'h0, 1'b0, -1);

    codes = {};
    for (int i = 0; i < 1100; i++) codes.push_back($urandom_range(0, 1) ? 15'h0001 : 15'h7FFF);
    run_edge(1100, 4'hF, 0, 0, 0, 2'd0, 15'h0, 1'b0, -1);
    codes = {};
    for (int i = 0; i < 600; i++) codes.push_back(15'h1234);
    run_edge(600, 4'hF, 0, 0, 0, 2'd0, 15'h0, 1'b0, 500);
    codes = '{15'h1234};
    run_edge(1, 4'hF, 0, 0, 0, 2'd0, 15'h0, 1'b0, -1);

    for (int e = 0; e < 40; e++) begin
      int n;
      if ($urandom_range(0, 2) == 0)
        cfg_write(2'($urandom_range(0, 3)), pool[$urandom_range(0, 15)], 1'($urandom_range(0, 1)));
      n = $urandom_range(1, 12);
      codes = {};
      for (int i = 0; i < n; i++) codes.push_back(pool[$urandom_range(0, 15)]);
      run_edge(n, 4'($urandom), $urandom_range(0, 3), 0, 0, 2'd0, 15'h0, 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
